key_debounce_encoder: RTL and testbench



---
 rtl/key_debounce_encoder_if.sv | 11 +
 rtl/key_debounce_encoder.sv | 160 ++++++++++++++++
 tb/tb_key_debounce_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_encoder_if.sv
// Key-side bundle of key_debounce_encoder: raw keys in, debounced level/press/load out.
// master drives the raw keys; slave is the debouncer.
interface key_debounce_encoder_if;
    logic [3:0] K;
    logic [3:0] O;
    logic [3:0] P;
    logic       L;

    modport master (output K, input O, input P, input L);
    modport slave  (input K, output O, output P, output L);
endinterface

// File: rtl/key_debounce_encoder.sv
// Four-key synchroniser + per-key debounce FSM producing stable levels, press pulses and load strobe.
// Optional KEY_AUTOREPEAT_EN: re-pulse P every REPEAT_CYCLES while a key stays held.
module key_debounce_encoder #(
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned REPEAT_CYCLES = 8
) (
    input  logic                  C,
    input  logic                  R,
    key_debounce_encoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPwait, StDown, StRwait} key_state_e;

    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W)) begin : g_bad_db
        $error("DB_CYCLES out of range for CNT_W");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rpt
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic [3:0]       s1_q, s2_q;
    key_state_e       state_q [4];
    key_state_e       state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       o_d, o_q, o_prev_q;
    logic [3:0]       p_d, p_q;
    logic             l_q;
    logic [3:0]       rpt_hit;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RPT_W-1:0] rpt_q [4];
    logic [RPT_W-1:0] rpt_d [4];

    // Repeat counter runs only while a key stays in DOWN; anything else clears it.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            rpt_hit[n] = 1'b0;
            rpt_d[n]   = '0;
            if (state_q[n] == StDown && state_d[n] == StDown) begin
                if (rpt_q[n] == RPT_W'(REPEAT_CYCLES - 1)) begin
                    rpt_hit[n] = 1'b1;
                end else begin
                    rpt_d[n] = rpt_q[n] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            for (int n = 0; n < 4; n++) rpt_q[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) rpt_q[n] <= rpt_d[n];
        end
    end
`else
    assign rpt_hit = 4'b0000;
`endif

    // State register, including synchroniser and counters.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            s1_q <= '0;
            s2_q <= '0;
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= StIdle;
                cnt_q[n]   <= '0;
            end
        end else begin
            s1_q <= bus.K;
            s2_q <= s1_q;
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // Next-state logic: each key is an independent debouncer on its s2 sample.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            unique case (state_q[n])
                StIdle: begin
                    if (s2_q[n]) begin
                        state_d[n] = StPwait;
                        cnt_d[n]   = '0;
                    end
                end
                StPwait: begin
                    if (!s2_q[n]) begin
                        state_d[n] = StIdle;
                        cnt_d[n]   = '0;
                    end else if (cnt_q[n] == CNT_W'(DB_CYCLES - 1)) begin
                        state_d[n] = StDown;
                        cnt_d[n]   = '0;
                    end else begin
                        cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    end
                end
                StDown: begin
                    if (!s2_q[n]) begin
                        state_d[n] = StRwait;
                        cnt_d[n]   = '0;
                    end
                end
                StRwait: begin
                    if (s2_q[n]) begin
                        state_d[n] = StDown;
                        cnt_d[n]   = '0;
                    end else if (cnt_q[n] == CNT_W'(DB_CYCLES - 1)) begin
                        state_d[n] = StIdle;
                        cnt_d[n]   = '0;
                    end else begin
                        cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[n] = StIdle;
                    cnt_d[n]   = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so O and P register on the accepting edge.
    always_comb begin
        o_d = '0;
        p_d = '0;
        for (int n = 0; n < 4; n++) begin
            o_d[n] = (state_d[n] == StDown) || (state_d[n] == StRwait);
            p_d[n] = ((state_q[n] == StPwait) && (state_d[n] == StDown)) || rpt_hit[n];
        end
    end

    // L compares O with its one-cycle-delayed copy, so it fires the cycle after O settles.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            o_q      <= '0;
            o_prev_q <= '0;
            p_q      <= '0;
            l_q      <= 1'b0;
        end else begin
            o_q      <= o_d;
            o_prev_q <= o_q;
            p_q      <= p_d;
            l_q      <= (o_q != o_prev_q);
        end
    end

    assign bus.O = o_q;
    assign bus.P = p_q;
    assign bus.L = l_q;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed self-checking bench for key_debounce_encoder (DB_CYCLES=4, REPEAT_CYCLES=8).
module tb_key_debounce_encoder;

    logic C = 1'b0;
    logic R = 1'b1;
    int   checks = 0;
    int   errors = 0;

    key_debounce_encoder_if bus ();

    key_debounce_encoder #(
        .DB_CYCLES    (4),
        .CNT_W        (5),
        .REPEAT_CYCLES(8)
    ) dut (
        .C  (C),
        .R  (R),
        .bus(bus)
    );

    always #5 C = ~C;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge C);
        #1;
    endtask

    task automatic apply_reset();
        bus.K = 4'b0000;
        R = 1'b1;
        step(2);
        R = 1'b0;
    endtask

    task automatic test_reset();
        bus.K = 4'b0000;
        #2;
        checks++;
        if ({bus.O, bus.P, bus.L} !== 9'b0) begin
            errors++;
            $display("FAIL reset_initial O=%b P=%b L=%b want all 0", bus.O, bus.P, bus.L);
        end
        step(2);
        R = 1'b0;
        bus.K = 4'b0001;
        step(4);
        R = 1'b1;
        #1;
        checks++;
        if ({bus.O, bus.P, bus.L} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_pwait O=%b P=%b L=%b want all 0", bus.O, bus.P, bus.L);
        end
        step(1);
        R = 1'b0;
        step(6);
        checks++;
        if (bus.O !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_e6 O=%b want 0000", bus.O);
        end
        step(1);
        checks++;
        if (bus.O !== 4'b0001 || bus.P !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release_e7 O=%b P=%b want 0001 0001", bus.O, bus.P);
        end
        step(1);
        checks++;
        if (bus.L !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_l L=%b want 1", bus.L);
        end
        // Raise R between edges while O and L are high: clear must be immediate.
        #2;
        R = 1'b1;
        #1;
        checks++;
        if ({bus.O, bus.P, bus.L} !== 9'b0) begin
            errors++;
            $display("FAIL reset_async O=%b P=%b L=%b want all 0", bus.O, bus.P, bus.L);
        end
        bus.K = 4'b0000;
        step(2);
        R = 1'b0;
    endtask

    task automatic test_clean_press();
        apply_reset();
        bus.K = 4'b0101;
        step(6);
        checks++;
        if (bus.O !== 4'b0000 || bus.L !== 1'b0) begin
            errors++;
            $display("FAIL press_e6 O=%b L=%b want 0000 0", bus.O, bus.L);
        end
        step(1);
        checks++;
        if (bus.O !== 4'b0101 || bus.P !== 4'b0101 || bus.L !== 1'b0) begin
            errors++;
            $display("FAIL press_e7 O=%b P=%b L=%b want 0101 0101 0", bus.O, bus.P, bus.L);
        end
        step(1);
        checks++;
        if (bus.O !== 4'b0101 || bus.P !== 4'b0000 || bus.L !== 1'b1) begin
            errors++;
            $display("FAIL press_e8 O=%b P=%b L=%b want 0101 0000 1", bus.O, bus.P, bus.L);
        end
        step(1);
        checks++;
        if (bus.L !== 1'b0 || bus.P !== 4'b0000) begin
            errors++;
            $display("FAIL press_e9 P=%b L=%b want 0000 0", bus.P, bus.L);
        end
    endtask

    // Continues from O=0101 left by test_clean_press.
    task automatic test_release();
        bus.K = 4'b0001;
        step(6);
        checks++;
        if (bus.O !== 4'b0101 || bus.L !== 1'b0) begin
            errors++;
            $display("FAIL release_e6 O=%b L=%b want 0101 0", bus.O, bus.L);
        end
        step(1);
        checks++;
        if (bus.O !== 4'b0001 || bus.P !== 4'b0000 || bus.L !== 1'b0) begin
            errors++;
            $display("FAIL release_e7 O=%b P=%b L=%b want 0001 0000 0", bus.O, bus.P, bus.L);
        end
        step(1);
        checks++;
        if (bus.L !== 1'b1 || bus.P !== 4'b0000) begin
            errors++;
            $display("FAIL release_e8 P=%b L=%b want 0000 1", bus.P, bus.L);
        end
        step(1);
        checks++;
        if (bus.L !== 1'b0) begin
            errors++;
            $display("FAIL release_e9 L=%b want 0", bus.L);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        apply_reset();
        pat = 8'b0011_0011;
        for (int c = 0; c < 20; c++) begin
            bus.K = (c < 8) ? {1'b0, pat[7 - c], 2'b00} : 4'b0000;
            step(1);
            checks++;
            if ({bus.O, bus.P, bus.L} !== 9'b0) begin
                errors++;
                $display("FAIL bounce_c%0d O=%b P=%b L=%b want all 0", c, bus.O, bus.P, bus.L);
            end
        end
    endtask

    task automatic test_staggered();
        logic [3:0] exp_o [12];
        logic       exp_l [12];
        apply_reset();
        for (int e = 1; e <= 11; e++) begin
            exp_o[e] = (e >= 9) ? 4'b1001 : (e >= 7) ? 4'b0001 : 4'b0000;
            exp_l[e] = (e == 8) || (e == 10);
        end
        bus.K = 4'b0001;
        for (int e = 1; e <= 11; e++) begin
            if (e == 3) bus.K = 4'b1001;
            step(1);
            checks++;
            if (bus.O !== exp_o[e] || bus.L !== exp_l[e]) begin
                errors++;
                $display("FAIL stagger_e%0d O=%b L=%b want %b %b",
                         e, bus.O, bus.L, exp_o[e], exp_l[e]);
            end
        end
    endtask

    // Long hold: one press pulse by default, repeats every 8 cycles with auto-repeat.
    task automatic test_hold();
        logic [3:0] exp_p;
        int         l_count;
        apply_reset();
        l_count = 0;
        bus.K = 4'b1000;
        for (int e = 1; e <= 30; e++) begin
            step(1);
`ifdef KEY_AUTOREPEAT_EN
            exp_p = (e == 7 || e == 15 || e == 23) ? 4'b1000 : 4'b0000;
`else
            exp_p = (e == 7) ? 4'b1000 : 4'b0000;
`endif
            if (bus.L === 1'b1) l_count++;
            checks++;
            if (bus.P !== exp_p || bus.O !== ((e >= 7) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL hold_e%0d O=%b P=%b want P=%b", e, bus.O, bus.P, exp_p);
            end
        end
        checks++;
        if (l_count != 1) begin
            errors++;
            $display("FAIL hold_l_count got %0d want 1", l_count);
        end
    endtask

    initial begin
        bus.K = 4'b0000;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_staggered();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
